// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// state encoding and the width of one adder slice.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry.sv
// The existing 4-bit ripple-carry adder slice, time-shared by the sequencer.
module ripple_carry (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic c1_s;
    logic c2_s;
    logic c3_s;

    // Carry chain spelled out bit by bit so each carry is its own net
    always_comb begin
        c1_s   = (a[0] & b[0]) | (cin  & (a[0] ^ b[0]));
        c2_s   = (a[1] & b[1]) | (c1_s & (a[1] ^ b[1]));
        c3_s   = (a[2] & b[2]) | (c2_s & (a[2] ^ b[2]));
        cout   = (a[3] & b[3]) | (c3_s & (a[3] ^ b[3]));
        sum[0] = a[0] ^ b[0] ^ cin;
        sum[1] = a[1] ^ b[1] ^ c1_s;
        sum[2] = a[2] ^ b[2] ^ c2_s;
        sum[3] = a[3] ^ b[3] ^ c3_s;
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision add/subtract sequencer: one nibble per cycle, LSB first,
// through a single shared ripple_carry slice with a start/busy/done handshake.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         sub,
    input  logic                         cin,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    output logic                         busy,
    output logic                         done,
    output logic [NIBBLE_W*NIBBLES-1:0]  s,
    output logic                         cout,
    output logic                         ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  carry_r;
    logic [W-1:0]          opa_r;
    logic [W-1:0]          opb_r;
    logic                  busy_r;
    logic                  done_r;
    logic [W-1:0]          s_r;
    logic                  cout_r;
    logic                  ovf_r;

    logic [NIBBLE_W-1:0]   nib_a_s;
    logic [NIBBLE_W-1:0]   nib_b_s;
    logic [NIBBLE_W-1:0]   nib_sum_s;
    logic                  nib_cout_s;
    logic                  last_s;

    // Select the active nibble of each operand for the shared adder
    always_comb begin
        nib_a_s = opa_r[{idx_r, 2'b00} +: NIBBLE_W];
        nib_b_s = opb_r[{idx_r, 2'b00} +: NIBBLE_W];
        last_s  = (idx_r == IDX_W'(NIBBLES - 1));
    end

    ripple_carry u_slice (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .cin  (carry_r),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // Sequencer: operand capture, nibble stepping and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            carry_r <= 1'b0;
            opa_r   <= '0;
            opb_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1, so invert B once at capture
                        opa_r   <= a;
                        opb_r   <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= '0;
                        s_r     <= '0;
                        cout_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                RUN: begin
                    s_r[{idx_r, 2'b00} +: NIBBLE_W] <= nib_sum_s;
                    carry_r <= nib_cout_s;
                    if (last_s) begin
                        idx_r   <= '0;
                        cout_r  <= nib_cout_s;
                        ovf_r   <= (opa_r[W-1] == opb_r[W-1]) &&
                                   (nib_sum_s[NIBBLE_W-1] != opa_r[W-1]);
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
